// File: rtl/noc_result_tx.sv
// noc_result_tx: buffers 64-bit result words and serializes each one as an
// 8-byte NOC Write packet, appending a completion Message after each block.
module noc_result_tx #(
  parameter logic [7:0]  DEST_ID     = 8'h01,
  parameter logic [7:0]  SRC_ID      = 8'h02,
  parameter int unsigned BLOCK_WORDS = 25,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  output logic        noc_from_dev_ctl,
  output logic [7:0]  noc_from_dev_data
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]      LastIdx = 8'(BLOCK_WORDS - 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] StopLvl = CntW'(FIFO_DEPTH - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

  localparam logic [7:0] HdrWrite = 8'h1A;  // Alen 0, Dlen 3 (8 bytes), Write
  localparam logic [7:0] HdrMsg   = 8'h05;  // Alen 0, Dlen 0 (1 byte), Message

  typedef enum logic [3:0] {
    StIdle, StWHdr, StWDst, StWSrc, StWAddr, StWData,
    StMHdr, StMDst, StMSrc, StMAddr, StMData
  } state_e;

  logic [64:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count, count_next;
  logic            push, pop;
  logic [64:0]     head;
  logic [7:0]      new_idx;

  state_e     state;
  logic [63:0] word;
  logic [2:0]  byte_cnt;
  logic [7:0]  word_idx;  // index of the word currently being sent
  logic [7:0]  next_idx;  // index a non-first word will take
  logic [7:0]  seq;

  // Pop whenever the bus is free for a new Write packet; push may use the slot freed by a pop.
  always_comb begin
    head = mem[rd_ptr];
    case (state)
      StIdle:  pop = (count != '0);
      StWData: pop = (byte_cnt == 3'd7) && (word_idx != LastIdx) && (count != '0);
      StMData: pop = (count != '0);
      default: pop = 1'b0;
    endcase
    push       = pushout && ((count != DepthC) || pop);
    count_next = count + CntW'(push) - CntW'(pop);
    new_idx    = head[64] ? 8'd0 : next_idx;
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {firstout, dout};
  end

  // FIFO pointers, occupancy and registered backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stopout <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      count   <= count_next;
      stopout <= (count_next >= StopLvl);
    end
  end

  // Packet FSM with registered bus outputs; a pop always launches a Write header.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= StIdle;
      noc_from_dev_ctl  <= 1'b1;
      noc_from_dev_data <= 8'h00;
      word              <= '0;
      byte_cnt          <= '0;
      word_idx          <= '0;
      next_idx          <= '0;
      seq               <= '0;
    end else begin
      case (state)
        StIdle: begin
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= 8'h00;
        end
        StWHdr: begin
          state             <= StWDst;
          noc_from_dev_ctl  <= 1'b0;
          noc_from_dev_data <= DEST_ID;
        end
        StWDst: begin
          state             <= StWSrc;
          noc_from_dev_data <= SRC_ID;
        end
        StWSrc: begin
          state             <= StWAddr;
          noc_from_dev_data <= {word_idx[4:0], 3'b000};
        end
        StWAddr: begin
          state             <= StWData;
          byte_cnt          <= 3'd0;
          noc_from_dev_data <= word[7:0];
          word              <= word >> 8;
        end
        StWData: begin
          if (byte_cnt != 3'd7) begin
            byte_cnt          <= byte_cnt + 3'd1;
            noc_from_dev_data <= word[7:0];
            word              <= word >> 8;
          end else if (word_idx == LastIdx) begin
            state             <= StMHdr;
            noc_from_dev_ctl  <= 1'b1;
            noc_from_dev_data <= HdrMsg;
          end else begin
            state             <= StIdle;
            noc_from_dev_ctl  <= 1'b1;
            noc_from_dev_data <= 8'h00;
          end
        end
        StMHdr: begin
          state             <= StMDst;
          noc_from_dev_ctl  <= 1'b0;
          noc_from_dev_data <= DEST_ID;
        end
        StMDst: begin
          state             <= StMSrc;
          noc_from_dev_data <= SRC_ID;
        end
        StMSrc: begin
          state             <= StMAddr;
          noc_from_dev_data <= 8'h00;
        end
        StMAddr: begin
          state             <= StMData;
          noc_from_dev_data <= seq;
        end
        StMData: begin
          state             <= StIdle;
          seq               <= seq + 8'd1;
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= 8'h00;
        end
        default: begin
          state             <= StIdle;
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= 8'h00;
        end
      endcase
      if (pop) begin
        state             <= StWHdr;
        noc_from_dev_ctl  <= 1'b1;
        noc_from_dev_data <= HdrWrite;
        word              <= head[63:0];
        word_idx          <= new_idx;
        // The block's last word clears the running index ahead of its Message.
        next_idx          <= (new_idx == LastIdx) ? 8'd0 : new_idx + 8'd1;
      end
    end
  end

endmodule
